// File: rtl/npu_ctrl_pkg.sv
// Shared definitions for the NPU tile controller: array op encodings and sequencer states.
package npu_ctrl_pkg;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_CLR = 3'd1;
  localparam logic [2:0] OP_MAC = 3'd2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/sa_valid_pipe.sv
// 1-bit strobe delay line: dout follows din exactly DEPTH cycles later (DEPTH >= 1).
module sa_valid_pipe #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk or posedge reset) begin
        if (reset) sr <= '0;
        else       sr <= din;
      end
    end else begin : g_multi
      always_ff @(posedge clk or posedge reset) begin
        if (reset) sr <= '0;
        else       sr <= {sr[DEPTH-2:0], din};
      end
    end
  endgenerate

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/systolic_ctrl.sv
// GEMM tile sequencer for the systolic array: CLEAR, stream k vectors, drain results to obuf.
// Optional perf counters are built when SYSTOLIC_CTRL_PERF_EN is defined.
module systolic_ctrl
  import npu_ctrl_pkg::*;
#(
  parameter int unsigned ARRAY_N    = 16,
  parameter int unsigned ARRAY_M    = 16,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned BUF_RD_LAT = 1,
  parameter int unsigned RESULT_LAT = ARRAY_N + ARRAY_M + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_k,
  input  logic [ADDR_W-1:0] cmd_ibuf_base,
  input  logic [ADDR_W-1:0] cmd_wbuf_base,
  input  logic [ADDR_W-1:0] cmd_obuf_base,
  output logic              ibuf_rd_en,
  output logic [ADDR_W-1:0] ibuf_rd_addr,
  output logic              wbuf_rd_en,
  output logic [ADDR_W-1:0] wbuf_rd_addr,
  output logic [2:0]        op_sig,
  output logic              obuf_wr_en,
  output logic [ADDR_W-1:0] obuf_wr_addr,
  output logic              busy,
  output logic              done
`ifdef SYSTOLIC_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_busy_cycles,
  output logic [15:0]       perf_tiles
`endif
);

  // +1 accounts for the array output register after the result latency.
  localparam int unsigned WR_LAT = BUF_RD_LAT + RESULT_LAT + 1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] k_q, ib_q, wb_q, ob_q;
  logic [ADDR_W-1:0] rd_cnt, wr_cnt;
  logic              rd_en, mac_v, wr_v, accept;

  assign accept = cmd_valid && (state == S_IDLE);
  assign rd_en  = (state == S_FEED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (cmd_valid) state_nxt = S_CLEAR;
      S_CLEAR: state_nxt = (k_q == '0) ? S_DONE : S_FEED;
      S_FEED:  if (rd_cnt == k_q - ADDR_W'(1)) state_nxt = S_DRAIN;
      S_DRAIN: if (wr_v && (wr_cnt == k_q - ADDR_W'(1))) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Write count runs independently of state: for large k, writes begin while still feeding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_q    <= '0;
      ib_q   <= '0;
      wb_q   <= '0;
      ob_q   <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (accept) begin
        k_q    <= cmd_k;
        ib_q   <= cmd_ibuf_base;
        wb_q   <= cmd_wbuf_base;
        ob_q   <= cmd_obuf_base;
        rd_cnt <= '0;
        wr_cnt <= '0;
      end else begin
        if (rd_en) rd_cnt <= rd_cnt + ADDR_W'(1);
        if (wr_v)  wr_cnt <= wr_cnt + ADDR_W'(1);
      end
    end
  end

  sa_valid_pipe #(.DEPTH(BUF_RD_LAT)) u_op_pipe (
    .clk   (clk),
    .reset (reset),
    .din   (rd_en),
    .dout  (mac_v)
  );

  sa_valid_pipe #(.DEPTH(WR_LAT)) u_wr_pipe (
    .clk   (clk),
    .reset (reset),
    .din   (rd_en),
    .dout  (wr_v)
  );

  always_comb begin
    cmd_ready    = (state == S_IDLE);
    busy         = (state != S_IDLE);
    done         = (state == S_DONE);
    ibuf_rd_en   = rd_en;
    wbuf_rd_en   = rd_en;
    ibuf_rd_addr = '0;
    wbuf_rd_addr = '0;
    if (rd_en) begin
      ibuf_rd_addr = ib_q + rd_cnt;
      wbuf_rd_addr = wb_q + rd_cnt;
    end
    op_sig = OP_NOP;
    if (mac_v)                 op_sig = OP_MAC;
    else if (state == S_CLEAR) op_sig = OP_CLR;
    obuf_wr_en   = wr_v;
    obuf_wr_addr = wr_v ? (ob_q + wr_cnt) : '0;
  end

`ifdef SYSTOLIC_CTRL_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_busy_cycles <= '0;
      perf_tiles       <= '0;
    end else begin
      if (busy && (perf_busy_cycles != '1)) perf_busy_cycles <= perf_busy_cycles + 32'd1;
      if (done && (perf_tiles != '1))       perf_tiles       <= perf_tiles + 16'd1;
    end
  end
`endif

endmodule
